// File: rtl/demux16_seq_if.sv
// Bundle of the data, strobe and result signals for the sequential 1-to-N distributor.
// The master side drives the data and strobes; the slave side returns the captured lines.
interface demux16_seq_if #(
  parameter int unsigned SEL_W = 4
);
  localparam int unsigned N = 2 ** SEL_W;

  logic             d;
  logic [SEL_W-1:0] s;
  logic             load;
  logic             start;
  logic             in_valid;
  logic [N-1:0]     f;
  logic [SEL_W-1:0] idx;
  logic             busy;
  logic             done;

  modport master (
    output d, s, load, start, in_valid,
    input  f, idx, busy, done
  );

  modport slave (
    input  d, s, load, start, in_valid,
    output f, idx, busy, done
  );
endinterface

// File: rtl/demux16_seq.sv
// Sequential 1-to-N demultiplexer: single writes by select, or an LSB-first auto-scan
// that rebuilds a serial word into the parallel output lines.
module demux16_seq #(
  parameter int unsigned SEL_W          = 4,
  parameter bit          CLEAR_ON_START = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  demux16_seq_if.slave   bus
);
  localparam int unsigned N = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q;
  logic [N-1:0]     f_q;
  logic [SEL_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;

  // Every output is a flop; busy/done are updated alongside the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      f_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StScan;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            if (CLEAR_ON_START) f_q <= '0;
          end else if (bus.load) begin
            f_q[bus.s] <= bus.d;
          end
        end
        StScan: begin
          if (bus.in_valid) begin
            f_q[idx_q] <= bus.d;
            idx_q      <= idx_q + 1'b1;  // wraps to 0 after the last line
            if (idx_q == LastIdx) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.f    = f_q;
  assign bus.idx  = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_demux16_seq.sv
// Directed bench for demux16_seq: single writes, full and stalled scans, priority rules
// and asynchronous reset, with hand-computed expected values.
module tb_demux16_seq;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc_full;
  int   cyc_stall;

  demux16_seq_if #(.SEL_W(4)) bus ();

  demux16_seq #(
    .SEL_W          (4),
    .CLEAR_ON_START (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a scan of pat; after sa bits stall na cycles, after sb bits stall nb cycles.
  task automatic run_scan(input string tag, input logic [15:0] pat, input int sa, input int na,
                          input int sb, input int nb, output int cyc);
    int busy_cnt;
    cyc      = 0;
    busy_cnt = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc++;
    if (bus.busy) busy_cnt++;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.d        = pat[i];
      step();
      bus.in_valid = 1'b0;
      cyc++;
      if (bus.busy) busy_cnt++;
      if (i + 1 == sa || i + 1 == sb) begin
        for (int k = 0; k < ((i + 1 == sa) ? na : nb); k++) begin
          bus.d = ~bus.d;
          step();
          cyc++;
          if (bus.busy) busy_cnt++;
          check({tag, "_stall_idx"}, 32'(bus.idx), 32'(i + 1));
        end
      end
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_f"}, 32'(bus.f), 32'(pat));
    check({tag, "_idx_at_done"}, 32'(bus.idx), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(16 + na + nb));
    step();
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.d        = 1'b0;
    bus.s        = '0;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_f", 32'(bus.f), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Fill all lines, then reset asynchronously between edges.
    for (int i = 0; i < 16; i++) begin
      bus.load = 1'b1;
      bus.s    = 4'(i);
      bus.d    = 1'b1;
      step();
    end
    bus.load = 1'b0;
    check("fill_f", 32'(bus.f), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_f", 32'(bus.f), 32'h0);
    check("async_rst_idx", 32'(bus.idx), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    step();
    check("held_rst_f", 32'(bus.f), 32'h0);
    rst_n = 1'b1;

    // Single writes.
    bus.load = 1'b1; bus.s = 4'd9; bus.d = 1'b1;
    step();
    check("wr9_set", 32'(bus.f), 32'h0200);
    bus.s = 4'd2; bus.d = 1'b1;
    step();
    check("wr2_set", 32'(bus.f), 32'h0204);
    bus.s = 4'd9; bus.d = 1'b0;
    step();
    check("wr9_clr", 32'(bus.f), 32'h0004);
    bus.load = 1'b0;
    step();
    check("idle_hold", 32'(bus.f), 32'h0004);

    run_scan("full", 16'hA5C3, 0, 0, 0, 0, cyc_full);
    run_scan("stall", 16'hA5C3, 5, 3, 11, 1, cyc_stall);
    check("stall_latency", 32'(cyc_stall - cyc_full), 32'd4);

    // start beats load; load/start ignored in scan; start ignored in DONE.
    bus.start = 1'b1; bus.load = 1'b1; bus.s = 4'd2; bus.d = 1'b1;
    step();
    bus.start = 1'b0;
    check("prio_f_cleared", 32'(bus.f), 32'h0);
    check("prio_busy", 32'(bus.busy), 32'd1);
    bus.s = 4'd0; bus.d = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("scan_load_ignored", 32'(bus.f), 32'h0);
    check("scan_stall_idx", 32'(bus.idx), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.d        = (i == 2 || i == 4 || i == 5 || i == 9 || i == 12);
      step();
    end
    bus.in_valid = 1'b0;
    check("prio_scan_f", 32'(bus.f), 32'h1234);
    check("prio_scan_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1; bus.load = 1'b1; bus.s = 4'd15; bus.d = 1'b1;
    step();
    bus.start = 1'b0; bus.load = 1'b0;
    check("done_start_ignored_busy", 32'(bus.busy), 32'd0);
    check("done_load_ignored_f", 32'(bus.f), 32'h1234);
    step();
    check("idle_after_done", 32'(bus.busy), 32'd0);

    // Reset in the middle of a scan.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.d        = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    check("mid_idx", 32'(bus.idx), 32'd7);
    check("mid_f", 32'(bus.f), 32'h007F);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_f", 32'(bus.f), 32'h0);
    check("mid_rst_idx", 32'(bus.idx), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_rst_no_done", 32'(bus.done), 32'd0);
    step();
    check("mid_rst_no_done2", 32'(bus.done), 32'd0);
    run_scan("post_rst", 16'h5A3C, 0, 0, 0, 0, cyc_full);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
